// File: rtl/regfile_scoreboard_if.sv
// Register-file / scoreboard bus: writeback, issue, flush, two read ports and the pending count.
// The master drives the requests and the slave (the register file) drives the read results.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              WE;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              Busy1;
  logic              Busy2;
  logic              IssueValid;
  logic [ADDR_W-1:0] IssueReg;
  logic              Flush;
  logic [ADDR_W:0]   PendingCount;

  modport master (
    output WE, WriteReg, WriteData, ReadReg1, ReadReg2, IssueValid, IssueReg, Flush,
    input  ReadData1, ReadData2, Busy1, Busy2, PendingCount
  );

  modport slave (
    input  WE, WriteReg, WriteData, ReadReg1, ReadReg2, IssueValid, IssueReg, Flush,
    output ReadData1, ReadData2, Busy1, Busy2, PendingCount
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending (scoreboard) bits; r0 is hardwired to zero.
// Define RF_BYPASS_EN to forward same-cycle writeback data and clear Busy on the read ports.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  Reset,
  regfile_scoreboard_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] file_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [ADDR_W:0]   count_q;
  logic              wb_hit;
  logic              iss_hit;

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + {{ADDR_W{1'b0}}, v[i]};
    return c;
  endfunction

  assign wb_hit  = bus.WE && (bus.WriteReg != '0);
  assign iss_hit = bus.IssueValid && (bus.IssueReg != '0);

  // Later assignments win: issue-set over flush over writeback-clear.
  always_comb begin
    pend_d = pend_q;
    if (wb_hit)    pend_d[bus.WriteReg] = 1'b0;
    if (bus.Flush) pend_d = '0;
    if (iss_hit)   pend_d[bus.IssueReg] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) file_q[i] <= '0;
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      if (wb_hit) file_q[bus.WriteReg] <= bus.WriteData;
      pend_q  <= pend_d;
      count_q <= popcount(pend_d);
    end
  end

  assign bus.PendingCount = count_q;

  always_comb begin
    bus.ReadData1 = (bus.ReadReg1 == '0) ? '0 : file_q[bus.ReadReg1];
    bus.ReadData2 = (bus.ReadReg2 == '0) ? '0 : file_q[bus.ReadReg2];
    bus.Busy1     = (bus.ReadReg1 != '0) && pend_q[bus.ReadReg1];
    bus.Busy2     = (bus.ReadReg2 != '0) && pend_q[bus.ReadReg2];
`ifdef RF_BYPASS_EN
    // A completing writeback satisfies the reader unless a new producer issues to the same register.
    if (wb_hit && (bus.ReadReg1 == bus.WriteReg)) begin
      bus.ReadData1 = bus.WriteData;
      bus.Busy1     = iss_hit && (bus.IssueReg == bus.ReadReg1);
    end
    if (wb_hit && (bus.ReadReg2 == bus.WriteReg)) begin
      bus.ReadData2 = bus.WriteData;
      bus.Busy2     = iss_hit && (bus.IssueReg == bus.ReadReg2);
    end
`endif
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus randomized bench for regfile_scoreboard against an array-based reference model.
// Builds with or without RF_BYPASS_EN; the model follows the same macro.
module tb_regfile_scoreboard;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic clk;
  logic Reset;
  int   n_vec;
  int   n_err;

  logic [31:0] mfile [DEPTH];
  bit          mpend [DEPTH];

  regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int r = 1; r < DEPTH; r++) if (mpend[r]) c++;
    return c;
  endfunction

  function automatic logic [31:0] model_rd(input int a);
    if (a == 0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (bus.WE && bus.WriteReg == a) return bus.WriteData;
`endif
    return mfile[a];
  endfunction

  function automatic bit model_busy(input int a);
    if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (bus.WE && bus.WriteReg == a) return bus.IssueValid && bus.IssueReg == a;
`endif
    return mpend[a];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      mfile[r] = 32'h0;
      mpend[r] = 1'b0;
    end
  endtask

  // Advance one edge and update the model from the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    if (Reset) begin
      for (int r = 1; r < DEPTH; r++) begin
        if (bus.IssueValid && bus.IssueReg == r) mpend[r] = 1'b1;
        else if (bus.Flush)                      mpend[r] = 1'b0;
        else if (bus.WE && bus.WriteReg == r)    mpend[r] = 1'b0;
      end
      if (bus.WE && bus.WriteReg != 0) mfile[bus.WriteReg] = bus.WriteData;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd1"},   {32'h0, bus.ReadData1},  {32'h0, model_rd(int'(bus.ReadReg1))});
    chk({tag, ".rd2"},   {32'h0, bus.ReadData2},  {32'h0, model_rd(int'(bus.ReadReg2))});
    chk({tag, ".busy1"}, {63'h0, bus.Busy1},      {63'h0, model_busy(int'(bus.ReadReg1))});
    chk({tag, ".busy2"}, {63'h0, bus.Busy2},      {63'h0, model_busy(int'(bus.ReadReg2))});
    chk({tag, ".cnt"},   {58'h0, bus.PendingCount}, 64'(model_count()));
  endtask

  task automatic idle();
    bus.WE = 1'b0; bus.WriteReg = '0; bus.WriteData = '0;
    bus.IssueValid = 1'b0; bus.IssueReg = '0; bus.Flush = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    bus.ReadReg1 = '0; bus.ReadReg2 = '0;
    Reset = 1'b0;
    model_reset();
    #1;
    bus.ReadReg1 = 5'd5; bus.ReadReg2 = 5'd31;
    #1;
    chk("rst.rd1", {32'h0, bus.ReadData1}, 64'h0);
    chk("rst.busy1", {63'h0, bus.Busy1}, 64'h0);
    chk("rst.cnt", {58'h0, bus.PendingCount}, 64'h0);
    #11 Reset = 1'b1;

    // Write r5 and make r10 pending, then pulse reset mid-cycle.
    bus.WE = 1'b1; bus.WriteReg = 5'd5; bus.WriteData = 32'h1234;
    bus.IssueValid = 1'b1; bus.IssueReg = 5'd10;
    tick();
    idle();
    bus.ReadReg1 = 5'd5; bus.ReadReg2 = 5'd10;
    #1 check_all("wr5");
    chk("wr5.val", {32'h0, bus.ReadData1}, 64'h1234);
    chk("wr5.cnt", {58'h0, bus.PendingCount}, 64'd1);
    bus.WE = 1'b1; bus.WriteReg = 5'd5; bus.WriteData = 32'hBEEF;
    bus.IssueValid = 1'b1; bus.IssueReg = 5'd11; bus.Flush = 1'b1;
    #1 Reset = 1'b0;
    model_reset();
    #1;
    chk("arst.rd", {32'h0, bus.ReadData1}, 64'h0);
    chk("arst.cnt", {58'h0, bus.PendingCount}, 64'h0);
    chk("arst.busy2", {63'h0, bus.Busy2}, 64'h0);
    tick();
    chk("rsthold.rd", {32'h0, bus.ReadData1}, 64'h0);
    chk("rsthold.cnt", {58'h0, bus.PendingCount}, 64'h0);
    #2 Reset = 1'b1;
    idle();
    bus.WE = 1'b1; bus.WriteReg = 5'd5; bus.WriteData = 32'h77;
    tick();
    idle();
    check_all("rel");
    chk("rel.rd", {32'h0, bus.ReadData1}, 64'h77);

    // r0 is never written and never pending.
    bus.WE = 1'b1; bus.WriteReg = 5'd0; bus.WriteData = 32'hFFFFFFFF;
    bus.IssueValid = 1'b1; bus.IssueReg = 5'd0;
    tick();
    idle();
    bus.ReadReg1 = 5'd0; bus.ReadReg2 = 5'd0;
    #1;
    chk("r0.rd", {32'h0, bus.ReadData1}, 64'h0);
    chk("r0.busy", {63'h0, bus.Busy1}, 64'h0);
    chk("r0.cnt", {58'h0, bus.PendingCount}, 64'h0);

    // Issue r3 then r7, then retire r3.
    bus.ReadReg1 = 5'd3; bus.ReadReg2 = 5'd7;
    bus.IssueValid = 1'b1; bus.IssueReg = 5'd3;
    tick();
    chk("iss3.cnt", {58'h0, bus.PendingCount}, 64'd1);
    bus.IssueReg = 5'd7;
    tick();
    idle();
    #1;
    chk("iss7.cnt", {58'h0, bus.PendingCount}, 64'd2);
    chk("iss7.busy3", {63'h0, bus.Busy1}, 64'd1);
    bus.WE = 1'b1; bus.WriteReg = 5'd3; bus.WriteData = 32'hA5A5A5A5;
    tick();
    idle();
    #1;
    check_all("wb3");
    chk("wb3.busy", {63'h0, bus.Busy1}, 64'd0);
    chk("wb3.cnt", {58'h0, bus.PendingCount}, 64'd1);
    chk("wb3.rd", {32'h0, bus.ReadData1}, 64'hA5A5A5A5);

    // Same-cycle issue and writeback to r9.
    bus.ReadReg1 = 5'd9;
    bus.IssueValid = 1'b1; bus.IssueReg = 5'd9;
    bus.WE = 1'b1; bus.WriteReg = 5'd9; bus.WriteData = 32'h55;
    tick();
    idle();
    #1;
    chk("r9.rd", {32'h0, bus.ReadData1}, 64'h55);
    chk("r9.busy", {63'h0, bus.Busy1}, 64'd1);
    chk("r9.cnt", {58'h0, bus.PendingCount}, 64'd2);

    // Flush together with a new issue.
    for (int k = 0; k < 3; k++) begin
      bus.IssueValid = 1'b1;
      bus.IssueReg = (k == 0) ? 5'd1 : (k == 1) ? 5'd2 : 5'd4;
      tick();
    end
    chk("pre.cnt", {58'h0, bus.PendingCount}, 64'd5);
    bus.IssueReg = 5'd6; bus.Flush = 1'b1;
    tick();
    idle();
    bus.ReadReg1 = 5'd6; bus.ReadReg2 = 5'd3;
    #1;
    check_all("flush");
    chk("flush.cnt", {58'h0, bus.PendingCount}, 64'd1);
    chk("flush.busy6", {63'h0, bus.Busy1}, 64'd1);
    chk("flush.rd3", {32'h0, bus.ReadData2}, 64'hA5A5A5A5);

    // Writeback to pending r8 while reading it.
    bus.WE = 1'b1; bus.WriteReg = 5'd8; bus.WriteData = 32'h1111;
    tick();
    bus.WE = 1'b0; bus.IssueValid = 1'b1; bus.IssueReg = 5'd8;
    tick();
    idle();
    bus.ReadReg1 = 5'd8;
    bus.WE = 1'b1; bus.WriteReg = 5'd8; bus.WriteData = 32'hDEAD;
    #1;
    check_all("byp");
`ifdef RF_BYPASS_EN
    chk("byp.rd", {32'h0, bus.ReadData1}, 64'hDEAD);
    chk("byp.busy", {63'h0, bus.Busy1}, 64'd0);
`else
    chk("byp.rd", {32'h0, bus.ReadData1}, 64'h1111);
    chk("byp.busy", {63'h0, bus.Busy1}, 64'd1);
`endif
    tick();
    idle();
    #1;
    chk("byp.next", {32'h0, bus.ReadData1}, 64'hDEAD);
    chk("byp.nbusy", {63'h0, bus.Busy1}, 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.IssueValid = ($urandom_range(0, 2) != 0);
      bus.IssueReg   = 5'($urandom_range(0, 31));
      bus.WE         = ($urandom_range(0, 1) != 0);
      bus.WriteReg   = (($urandom_range(0, 1) != 0)) ? bus.IssueReg ^ 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      bus.WriteData  = $urandom;
      bus.Flush      = ($urandom_range(0, 15) == 0);
      bus.ReadReg1   = ($urandom_range(0, 3) == 0) ? bus.WriteReg : 5'($urandom_range(0, 31));
      bus.ReadReg2   = 5'($urandom_range(0, 31));
      #1 check_all("rnd");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
